// File: rtl/ctl_pkg.sv
// Shared types and encodings for the multicycle control unit.
// State enum, opcode constants, ALU op codes and writeback sources.
package ctl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WAIT_EX,
        S_WB
    } state_t;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic IFU_ALU = 1'b0;
    localparam logic IFU_MU  = 1'b1;

    // Base ALU op selected by func3 (no func7 modifier applied)
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000: op = ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of RV32I ALU ops and RV32M multiplies.
// Anything outside that subset is reported as illegal.
module instr_decoder
    import ctl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [1:0] func7b50,
    output logic       bmuxctl,
    output logic [3:0] aluctl,
    output logic [1:0] mulctl,
    output logic       ifuresctl,
    output logic       is_mu,
    output logic       illegal
);

    // Field decode with safe defaults for every output
    always_comb begin
        bmuxctl   = 1'b0;
        aluctl    = ALU_ADD;
        mulctl    = func3[1:0];
        ifuresctl = IFU_ALU;
        is_mu     = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_R: begin
                case (func7b50)
                    2'b00: aluctl = alu_from_f3(func3);
                    2'b10: begin
                        if (func3 == 3'b000)
                            aluctl = ALU_SUB;
                        else if (func3 == 3'b101)
                            aluctl = ALU_SRA;
                        else
                            illegal = 1'b1;
                    end
                    2'b01: begin
                        if (!func3[2]) begin
                            is_mu     = 1'b1;
                            ifuresctl = IFU_MU;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_I: begin
                bmuxctl = 1'b1;
                aluctl  = alu_from_f3(func3);
                case (func3)
                    3'b001: begin
                        if (func7b50[0])
                            illegal = 1'b1;
                    end
                    3'b101: begin
                        if (func7b50 == 2'b10)
                            aluctl = ALU_SRA;
                        else if (func7b50 != 2'b00)
                            illegal = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM: fetch, decode, execute, writeback.
// Strobes decode from state; datapath selects are latched in DECODE.
module control_unit
    import ctl_pkg::*;
#(
    parameter int pcmux_N     = 2,
    parameter int ifuresctl_N = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           run,
    input  logic [6:0]                     opcode,
    input  logic [2:0]                     func3,
    input  logic [1:0]                     func7b50,
    input  logic                           exdone,
    output logic [$clog2(pcmux_N)-1:0]     pcmuxctl,
    output logic                           pcnextctl,
    output logic                           instrre,
    output logic                           regre,
    output logic                           regwe,
    output logic                           bmuxctl,
    output logic [3:0]                     aluctl,
    output logic                           mulstart,
    output logic [1:0]                     mulctl,
    output logic [$clog2(ifuresctl_N)-1:0] ifuresctl,
    output logic                           illegal,
    output logic [31:0]                    instret
);

    localparam int IW = $clog2(ifuresctl_N);

    state_t state, next_state;

    logic       dec_bmux;
    logic [3:0] dec_alu;
    logic [1:0] dec_mul;
    logic       dec_ifu;
    logic       dec_mu;
    logic       dec_ill;

    logic          bmux_q;
    logic [3:0]    alu_q;
    logic [1:0]    mul_q;
    logic [IW-1:0] ifu_q;
    logic          mu_q;
    logic          ill_q;
    logic [31:0]   instret_q;

    instr_decoder u_dec (
        .opcode    (opcode),
        .func3     (func3),
        .func7b50  (func7b50),
        .bmuxctl   (dec_bmux),
        .aluctl    (dec_alu),
        .mulctl    (dec_mul),
        .ifuresctl (dec_ifu),
        .is_mu     (dec_mu),
        .illegal   (dec_ill)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Capture decoded selects on the edge leaving DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bmux_q <= 1'b0;
            alu_q  <= ALU_ADD;
            mul_q  <= 2'b00;
            ifu_q  <= '0;
            mu_q   <= 1'b0;
            ill_q  <= 1'b0;
        end else if (state == S_DECODE) begin
            bmux_q <= dec_bmux;
            alu_q  <= dec_alu;
            mul_q  <= dec_mul;
            ifu_q  <= IW'(dec_ifu);
            mu_q   <= dec_mu;
            ill_q  <= dec_ill;
        end
    end

    // Retired-instruction counter, bumped on the edge leaving WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret_q <= 32'd0;
        else if (state == S_WB)
            instret_q <= instret_q + 32'd1;
    end

    // Next-state logic and per-state strobes
    always_comb begin
        next_state = state;
        pcnextctl  = 1'b0;
        instrre    = 1'b0;
        regre      = 1'b0;
        regwe      = 1'b0;
        mulstart   = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_IDLE: begin
                if (run)
                    next_state = S_FETCH;
            end
            S_FETCH: begin
                instrre    = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                regre      = 1'b1;
                next_state = S_EXEC;
            end
            S_EXEC: begin
                if (mu_q) begin
                    mulstart   = 1'b1;
                    next_state = S_WAIT_EX;
                end else begin
                    next_state = S_WB;
                end
            end
            S_WAIT_EX: begin
                if (exdone)
                    next_state = S_WB;
            end
            S_WB: begin
                pcnextctl  = 1'b1;
                regwe      = !ill_q;
                illegal    = ill_q;
                next_state = run ? S_FETCH : S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign pcmuxctl  = '0;
    assign bmuxctl   = bmux_q;
    assign aluctl    = alu_q;
    assign mulctl    = mul_q;
    assign ifuresctl = ifu_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: ALU, MU, illegal, reset, wrap.
// Each check is an immediate assertion with hand-computed values.
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [1:0]  func7b50;
    logic        exdone;
    logic [0:0]  pcmuxctl;
    logic        pcnextctl;
    logic        instrre;
    logic        regre;
    logic        regwe;
    logic        bmuxctl;
    logic [3:0]  aluctl;
    logic        mulstart;
    logic [1:0]  mulctl;
    logic [0:0]  ifuresctl;
    logic        illegal;
    logic [31:0] instret;

    int passed;
    int total;

    control_unit #(.pcmux_N(2), .ifuresctl_N(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .opcode    (opcode),
        .func3     (func3),
        .func7b50  (func7b50),
        .exdone    (exdone),
        .pcmuxctl  (pcmuxctl),
        .pcnextctl (pcnextctl),
        .instrre   (instrre),
        .regre     (regre),
        .regwe     (regwe),
        .bmuxctl   (bmuxctl),
        .aluctl    (aluctl),
        .mulstart  (mulstart),
        .mulctl    (mulctl),
        .ifuresctl (ifuresctl),
        .illegal   (illegal),
        .instret   (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic [1:0] f7);
        opcode   = op;
        func3    = f3;
        func7b50 = f7;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        run    = 1'b0;
        exdone = 1'b0;
        set_instr(7'b0110011, 3'b000, 2'b00);
        #12;
        check("rst_instrre", 32'(instrre), 32'd0);
        check("rst_regwe", 32'(regwe), 32'd0);
        check("rst_pcnext", 32'(pcnextctl), 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_aluctl", 32'(aluctl), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD
        cyc();
        check("idle_norun", 32'(instrre), 32'd0);
        run = 1'b1;
        cyc();
        check("add_fetch_instrre", 32'(instrre), 32'd1);
        check("add_fetch_regre", 32'(regre), 32'd0);
        cyc();
        check("add_dec_regre", 32'(regre), 32'd1);
        check("add_dec_instrre", 32'(instrre), 32'd0);
        cyc();
        check("add_exec_regwe", 32'(regwe), 32'd0);
        check("add_exec_aluctl", 32'(aluctl), 32'h0);
        check("add_exec_bmux", 32'(bmuxctl), 32'd0);
        check("add_exec_mulstart", 32'(mulstart), 32'd0);
        cyc();
        check("add_wb_regwe", 32'(regwe), 32'd1);
        check("add_wb_pcnext", 32'(pcnextctl), 32'd1);
        check("add_wb_pcmux", 32'(pcmuxctl), 32'd0);
        check("add_wb_illegal", 32'(illegal), 32'd0);
        check("add_wb_instret", instret, 32'd0);
        set_instr(7'b0010011, 3'b101, 2'b10);

        // SRAI
        cyc();
        check("srai_fetch_instret", instret, 32'd1);
        check("srai_fetch_instrre", 32'(instrre), 32'd1);
        cyc();
        cyc();
        check("srai_bmux", 32'(bmuxctl), 32'd1);
        check("srai_aluctl", 32'(aluctl), 32'h7);
        cyc();
        check("srai_wb_regwe", 32'(regwe), 32'd1);
        set_instr(7'b0110011, 3'b000, 2'b10);

        // SUB
        cyc();
        check("sub_fetch_instret", instret, 32'd2);
        cyc();
        cyc();
        check("sub_aluctl", 32'(aluctl), 32'h1);
        check("sub_bmux", 32'(bmuxctl), 32'd0);
        cyc();
        check("sub_wb_regwe", 32'(regwe), 32'd1);
        set_instr(7'b0110011, 3'b011, 2'b01);

        // MULHU, 5 WAIT_EX cycles -> 9 cycles total
        cyc();
        check("mul_c1_instrre", 32'(instrre), 32'd1);
        check("mul_c1_instret", instret, 32'd3);
        cyc();
        check("mul_c2_regre", 32'(regre), 32'd1);
        cyc();
        check("mul_c3_mulstart", 32'(mulstart), 32'd1);
        check("mul_c3_mulctl", 32'(mulctl), 32'h3);
        check("mul_c3_ifures", 32'(ifuresctl), 32'd1);
        cyc();
        check("mul_c4_mulstart", 32'(mulstart), 32'd0);
        check("mul_c4_regwe", 32'(regwe), 32'd0);
        cyc();
        cyc();
        cyc();
        check("mul_c7_regwe", 32'(regwe), 32'd0);
        check("mul_c7_pcnext", 32'(pcnextctl), 32'd0);
        check("mul_c7_mulstart", 32'(mulstart), 32'd0);
        cyc();
        exdone = 1'b1;
        check("mul_c8_regwe", 32'(regwe), 32'd0);
        cyc();
        exdone = 1'b0;
        check("mul_c9_regwe", 32'(regwe), 32'd1);
        check("mul_c9_pcnext", 32'(pcnextctl), 32'd1);
        check("mul_c9_ifures", 32'(ifuresctl), 32'd1);
        check("mul_c9_instret", instret, 32'd3);
        set_instr(7'b0110011, 3'b100, 2'b01);

        // DIV is illegal
        cyc();
        check("div_fetch_instret", instret, 32'd4);
        cyc();
        cyc();
        check("div_exec_mulstart", 32'(mulstart), 32'd0);
        check("div_exec_illegal", 32'(illegal), 32'd0);
        cyc();
        check("div_wb_illegal", 32'(illegal), 32'd1);
        check("div_wb_regwe", 32'(regwe), 32'd0);
        check("div_wb_pcnext", 32'(pcnextctl), 32'd1);
        set_instr(7'b0000011, 3'b010, 2'b00);

        // Load opcode is illegal
        cyc();
        check("ld_fetch_instret", instret, 32'd5);
        check("ld_fetch_illegal", 32'(illegal), 32'd0);
        cyc();
        cyc();
        cyc();
        check("ld_wb_illegal", 32'(illegal), 32'd1);
        check("ld_wb_regwe", 32'(regwe), 32'd0);
        set_instr(7'b0110011, 3'b011, 2'b01);

        // Reset while waiting on the MU
        cyc();
        check("rst2_fetch_instret", instret, 32'd6);
        cyc();
        cyc();
        check("rst2_exec_mulstart", 32'(mulstart), 32'd1);
        cyc();
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("arst_instret", instret, 32'd0);
        check("arst_mulctl", 32'(mulctl), 32'd0);
        check("arst_ifures", 32'(ifuresctl), 32'd0);
        check("arst_regwe", 32'(regwe), 32'd0);
        check("arst_pcnext", 32'(pcnextctl), 32'd0);
        #1;
        rst_n = 1'b1;
        cyc();
        cyc();
        exdone = 1'b1;
        cyc();
        exdone = 1'b0;
        cyc();
        check("post_rst_instrre", 32'(instrre), 32'd0);
        check("post_rst_regwe", 32'(regwe), 32'd0);
        check("post_rst_pcnext", 32'(pcnextctl), 32'd0);
        check("post_rst_instret", instret, 32'd0);

        // instret wrap
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        set_instr(7'b0110011, 3'b111, 2'b00);
        run = 1'b1;
        cyc();
        check("wrap_pre", instret, 32'hFFFF_FFFF);
        cyc();
        cyc();
        check("and_aluctl", 32'(aluctl), 32'h9);
        run = 1'b0;
        cyc();
        check("wrap_wb_regwe", 32'(regwe), 32'd1);
        cyc();
        check("wrap_post", instret, 32'h0000_0000);
        check("wrap_idle_instrre", 32'(instrre), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
